dcache_req_ctrl: RTL and testbench

//  Sequences the single data-cache port between the dual-issue EX stage and the DCache.

---
 rtl/dcache_req_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dcache_req_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_req_ctrl.sv
// rtl/dcache_req_ctrl.sv - single-port data-cache request sequencer between EX and DCache
//
// Purpose: accepts at most one aligned load/store per cycle from EX, registers it,
// holds it stable toward the DCache until the matching ready, stalls the pipeline
// while waiting, returns load data to MEM and keeps stall/timeout debug state.
//
// Ports:
//   clk, rstn                 clock, synchronous active-high reset
//   EX_mem_rvalid/wvalid      load / store request from EX
//   EX_mem_addr/wdata/type    request address, store data, access type
//   EX_flush                  blocks acceptance of the EX request this cycle
//   dc_rvalid/wvalid          registered request to DCache
//   dc_addr/wdata/type        registered request fields
//   dc_rready/wready/rdata    DCache completion handshake and load data
//   MEM_mem_rdata             last completed load data
//   MEM_mem_done              one-cycle completion pulse
//   stall_dcache              pipeline freeze while a request waits
//   ale, req_err              one-cycle rejection pulses
//   wait_cnt                  stall-cycle counter (wraps)
//   timeout                   sticky: a wait lasted TIMEOUT cycles

module dcache_req_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             EX_mem_rvalid,
    input  logic             EX_mem_wvalid,
    input  logic [31:0]      EX_mem_addr,
    input  logic [31:0]      EX_mem_wdata,
    input  logic [2:0]       EX_mem_type,
    input  logic             EX_flush,
    output logic             dc_rvalid,
    output logic             dc_wvalid,
    output logic [31:0]      dc_addr,
    output logic [31:0]      dc_wdata,
    output logic [2:0]       dc_type,
    input  logic             dc_rready,
    input  logic             dc_wready,
    input  logic [31:0]      dc_rdata,
    output logic [31:0]      MEM_mem_rdata,
    output logic             MEM_mem_done,
    output logic             stall_dcache,
    output logic             ale,
    output logic             req_err,
    output logic [CNT_W-1:0] wait_cnt,
    output logic             timeout
);

    localparam int AGE_W = $clog2(TIMEOUT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_is_store;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [2:0]       r_type;
    logic [31:0]      r_rdata;
    logic             r_done;
    logic             r_ale;
    logic             r_err;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [AGE_W-1:0] r_age;
    logic             r_timeout;

    logic w_match_ready;
    logic w_complete;
    logic w_stall;
    logic w_one_req;
    logic w_aligned;
    logic w_live;
    logic w_accept;

    always_comb begin
        w_match_ready = r_is_store ? dc_wready : dc_rready;
        w_complete    = (r_state == S_WAIT) & w_match_ready;
        w_stall       = (r_state == S_WAIT) & ~w_match_ready;
        w_one_req     = EX_mem_rvalid ^ EX_mem_wvalid;

        case (EX_mem_type)
            3'b000, 3'b001:         w_aligned = (EX_mem_addr[1:0] == 2'b00);
            3'b011, 3'b101, 3'b111: w_aligned = ~EX_mem_addr[0];
            default:                w_aligned = 1'b1;
        endcase

        // A stalled or flushed cycle neither accepts nor reports errors.
        w_live   = ~w_stall & ~EX_flush;
        w_accept = w_live & w_one_req & w_aligned;

        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = S_WAIT;
        end else if (w_complete) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state    <= S_IDLE;
            r_is_store <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_type     <= '0;
            r_rdata    <= '0;
            r_done     <= 1'b0;
            r_ale      <= 1'b0;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
            r_age      <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_complete;
            r_ale   <= w_live & w_one_req & ~w_aligned;
            r_err   <= w_live & EX_mem_rvalid & EX_mem_wvalid;

            if (w_accept) begin
                r_is_store <= EX_mem_wvalid;
                r_addr     <= EX_mem_addr;
                r_wdata    <= EX_mem_wdata;
                r_type     <= EX_mem_type;
                r_age      <= '0;
            end else if (w_stall && (r_age != AGE_MAX)) begin
                r_age <= r_age + AGE_W'(1);
            end

            if (w_complete && !r_is_store) begin
                r_rdata <= dc_rdata;
            end

            if (w_stall) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end

            // Debug only: the FSM keeps waiting regardless of the flag.
            if (r_age == AGE_MAX) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign dc_rvalid     = (r_state == S_WAIT) & ~r_is_store;
    assign dc_wvalid     = (r_state == S_WAIT) &  r_is_store;
    assign dc_addr       = r_addr;
    assign dc_wdata      = r_wdata;
    assign dc_type       = r_type;
    assign MEM_mem_rdata = r_rdata;
    assign MEM_mem_done  = r_done;
    assign stall_dcache  = w_stall;
    assign ale           = r_ale;
    assign req_err       = r_err;
    assign wait_cnt      = r_wait_cnt;
    assign timeout       = r_timeout;

endmodule

// File: tb/tb_dcache_req_ctrl.sv
// tb/tb_dcache_req_ctrl.sv - randomized scoreboard bench for dcache_req_ctrl

module tb_dcache_req_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        EX_mem_rvalid, EX_mem_wvalid;
    logic [31:0] EX_mem_addr, EX_mem_wdata;
    logic [2:0]  EX_mem_type;
    logic        EX_flush;
    logic        dc_rvalid, dc_wvalid;
    logic [31:0] dc_addr, dc_wdata;
    logic [2:0]  dc_type;
    logic        dc_rready, dc_wready;
    logic [31:0] dc_rdata;
    logic [31:0] MEM_mem_rdata;
    logic        MEM_mem_done, stall_dcache, ale, req_err, timeout;
    logic [31:0] wait_cnt;

    dcache_req_ctrl #(.CNT_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rstn(rstn),
        .EX_mem_rvalid(EX_mem_rvalid), .EX_mem_wvalid(EX_mem_wvalid),
        .EX_mem_addr(EX_mem_addr), .EX_mem_wdata(EX_mem_wdata),
        .EX_mem_type(EX_mem_type), .EX_flush(EX_flush),
        .dc_rvalid(dc_rvalid), .dc_wvalid(dc_wvalid),
        .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_type(dc_type),
        .dc_rready(dc_rready), .dc_wready(dc_wready), .dc_rdata(dc_rdata),
        .MEM_mem_rdata(MEM_mem_rdata), .MEM_mem_done(MEM_mem_done),
        .stall_dcache(stall_dcache), .ale(ale), .req_err(req_err),
        .wait_cnt(wait_cnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          stamp;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  typ;
        logic        st;
    } req_t;

    typedef struct {
        int          stamp;
        logic [31:0] rdata;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];
    int    ale_q[$];
    int    err_q[$];

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    bit          model_busy = 0;
    bit          cur_st     = 0;
    int          dly        = 0;
    logic [31:0] last_load  = '0;
    int          model_wait = 0;
    bit          exp_stall  = 0;
    bit          mon_en     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_aligned(input logic [2:0] t, input logic [31:0] a);
        if (t == 3'b000 || t == 3'b001) return (a % 4) == 0;
        if (t == 3'b011 || t == 3'b101 || t == 3'b111) return (a % 2) == 0;
        return 1'b1;
    endfunction

    // One cycle of DCache responder plus EX stimulus, driven at the falling edge.
    task automatic drive_cycle(input bit issue);
        int    e;
        bit    rdy;
        int    r;
        req_t  rq;
        done_t dn;
        logic [2:0] ld_types[5];
        logic [2:0] st_types[3];
        ld_types = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101};
        st_types = '{3'b001, 3'b110, 3'b111};
        e   = cyc + 1;
        rdy = 0;
        dc_rready = 1'b0;
        dc_wready = 1'b0;
        dc_rdata  = $urandom;
        if (model_busy) begin
            if (dly == 0) begin
                rdy = 1;
                if (cur_st) dc_wready = 1'b1;
                else begin
                    dc_rready = 1'b1;
                    last_load = dc_rdata;
                end
                dn.stamp = e;
                dn.rdata = last_load;
                done_q.push_back(dn);
            end else begin
                dly--;
            end
            // Ready of the other kind must be ignored.
            if (cur_st) dc_rready = 1'($urandom_range(0, 1));
            else        dc_wready = 1'($urandom_range(0, 1));
        end
        exp_stall = model_busy && !rdy;
        if (exp_stall) model_wait++;
        if (rdy) model_busy = 0;

        EX_mem_rvalid = 1'b0;
        EX_mem_wvalid = 1'b0;
        EX_flush      = 1'b0;
        EX_mem_addr   = $urandom;
        EX_mem_wdata  = $urandom;
        EX_mem_type   = 3'($urandom_range(0, 7));
        if (issue) begin
            r = $urandom_range(0, 9);
            EX_flush = ($urandom_range(0, 9) == 0);
            if (r < 4) begin
                EX_mem_rvalid = 1'b1;
                EX_mem_type   = ld_types[$urandom_range(0, 4)];
            end else if (r < 7) begin
                EX_mem_wvalid = 1'b1;
                EX_mem_type   = st_types[$urandom_range(0, 2)];
            end else if (r == 7) begin
                EX_mem_rvalid = 1'b1;
                EX_mem_wvalid = 1'b1;
            end
        end

        if (!exp_stall && !EX_flush) begin
            if (EX_mem_rvalid && EX_mem_wvalid) begin
                err_q.push_back(e);
            end else if (EX_mem_rvalid || EX_mem_wvalid) begin
                if (is_aligned(EX_mem_type, EX_mem_addr)) begin
                    rq.stamp = e;
                    rq.addr  = EX_mem_addr;
                    rq.wdata = EX_mem_wdata;
                    rq.typ   = EX_mem_type;
                    rq.st    = EX_mem_wvalid;
                    req_q.push_back(rq);
                    model_busy = 1;
                    cur_st     = EX_mem_wvalid;
                    dly        = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 4);
                end else begin
                    ale_q.push_back(e);
                end
            end
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    req_t  m_cur;
    bit    m_prev_valid = 0;
    bit    m_prev_done  = 0;

    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            chk("stall", 32'(stall_dcache), 32'(exp_stall));
            if (dc_rvalid && dc_wvalid) chk("both_valid", 32'(1), 32'(0));
            if (dc_rvalid || dc_wvalid) begin
                if (!m_prev_valid || m_prev_done) begin
                    if (req_q.size() == 0) begin
                        chk("req_unexpected", 32'(1), 32'(0));
                    end else begin
                        m_cur = req_q.pop_front();
                        chk("req_cycle", 32'(cyc), 32'(m_cur.stamp));
                        chk("req_kind", 32'(dc_wvalid), 32'(m_cur.st));
                    end
                end
                chk("dc_addr", dc_addr, m_cur.addr);
                chk("dc_wdata", dc_wdata, m_cur.wdata);
                chk("dc_type", 32'(dc_type), 32'(m_cur.typ));
            end
            m_prev_valid = dc_rvalid || dc_wvalid;
            m_prev_done  = (dc_rvalid && dc_rready) || (dc_wvalid && dc_wready);

            if (MEM_mem_done) begin
                if (done_q.size() == 0) chk("done_unexpected", 32'(1), 32'(0));
                else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(d.stamp));
                    chk("mem_rdata", MEM_mem_rdata, d.rdata);
                end
            end
            if (ale) begin
                if (ale_q.size() == 0) chk("ale_unexpected", 32'(1), 32'(0));
                else chk("ale_cycle", 32'(cyc), 32'(ale_q.pop_front()));
            end
            if (req_err) begin
                if (err_q.size() == 0) chk("err_unexpected", 32'(1), 32'(0));
                else chk("err_cycle", 32'(cyc), 32'(err_q.pop_front()));
            end
        end else begin
            m_prev_valid = 0;
            m_prev_done  = 0;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rvalid"}, 32'(dc_rvalid), 32'(0));
        chk({tag, "_wvalid"}, 32'(dc_wvalid), 32'(0));
        chk({tag, "_stall"}, 32'(stall_dcache), 32'(0));
        chk({tag, "_done"}, 32'(MEM_mem_done), 32'(0));
        chk({tag, "_ale"}, 32'(ale), 32'(0));
        chk({tag, "_err"}, 32'(req_err), 32'(0));
        chk({tag, "_rdata"}, MEM_mem_rdata, 32'(0));
        chk({tag, "_wait_cnt"}, wait_cnt, 32'(0));
        chk({tag, "_timeout"}, 32'(timeout), 32'(0));
    endtask

    initial begin
        rstn = 1'b1;
        EX_mem_rvalid = 1'b0; EX_mem_wvalid = 1'b0;
        EX_mem_addr = '0; EX_mem_wdata = '0; EX_mem_type = '0; EX_flush = 1'b0;
        dc_rready = 1'b0; dc_wready = 1'b0; dc_rdata = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rstn   = 1'b0;
        mon_en = 1;

        for (int i = 0; i < 720; i++) begin
            @(negedge clk);
            drive_cycle(i < 700);
        end
        @(negedge clk);
        #3;
        mon_en = 0;
        chk("left_req", 32'(req_q.size()), 32'(0));
        chk("left_done", 32'(done_q.size()), 32'(0));
        chk("left_ale", 32'(ale_q.size()), 32'(0));
        chk("left_err", 32'(err_q.size()), 32'(0));
        chk("wait_cnt", wait_cnt, 32'(model_wait));
        chk("no_timeout", 32'(timeout), 32'(0));

        // Load that never completes: the sticky timeout must rise after 16 wait cycles.
        @(negedge clk);
        dc_rready = 1'b0; dc_wready = 1'b0;
        EX_mem_rvalid = 1'b1; EX_mem_type = 3'b000; EX_mem_addr = 32'h100; EX_flush = 1'b0;
        @(negedge clk);
        EX_mem_rvalid = 1'b0;
        repeat (14) @(negedge clk);
        chk("to_early", 32'(timeout), 32'(0));
        chk("to_stall", 32'(stall_dcache), 32'(1));
        chk("to_rvalid", 32'(dc_rvalid), 32'(1));
        chk("to_addr", dc_addr, 32'h100);
        repeat (6) @(negedge clk);
        chk("to_set", 32'(timeout), 32'(1));
        chk("to_hold", 32'(dc_rvalid), 32'(1));

        rstn = 1'b1;
        @(negedge clk);
        chk_all_zero("midwait_reset");
        rstn = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
